// File: rtl/core_control_sequencer_pkg.sv
// Shared control-sequencer types: ctrl_cycle enum and default beat-counter width.
// Optional feature macro: CORE_CTRL_SEQ_COPROC_EN (adds the COPROC cycle).
package core_control_sequencer_pkg;

  localparam int unsigned BEAT_W_DEFAULT = 4;

  typedef enum logic [3:0] {
    ISSUE,
    RD_INDIRECT_SHIFT,
    WITH_SHIFT,
    TRANSFER,
    BASE_WRITEBACK,
    MUL_ACC_LD,
    MUL,
    MUL_HI_WB,
    EXCEPTION
`ifdef CORE_CTRL_SEQ_COPROC_EN
    ,
    COPROC
`endif
  } ctrl_cycle_t;

endpackage

// File: rtl/core_control_beat_counter.sv
// Load/increment/decrement/clear counter shared by the beat index and the multiply timer.
// Priority: clear > load > increment > decrement. Increment saturates at all-ones, decrement at zero.
module core_control_beat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Counter register with saturating step in either direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_inc) begin
      if (r_count != '1) r_count <= r_count + 1'b1;
    end else if (i_dec) begin
      if (r_count != '0) r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/core_control_sequencer.sv
// Per-instruction control-cycle sequencer: sequences issued instructions through shift, block transfer,
// multiply and exception phases, with stall hold and bubble flush.
// Optional feature macro: CORE_CTRL_SEQ_COPROC_EN (coproc/cp_ready ports and COPROC cycle).
module core_control_sequencer
  import core_control_sequencer_pkg::*;
#(
  parameter int unsigned BEAT_W      = BEAT_W_DEFAULT,
  parameter int unsigned MUL_LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              bubble,
  input  logic              exception,
  input  logic              mul,
  input  logic              mul_add,
  input  logic              mul_long,
  input  logic              mul_ready,
  input  logic              ldst,
  input  logic [BEAT_W-1:0] ldst_beats,
  input  logic              ldst_writeback,
  input  logic              mem_ready,
  input  logic              pop_valid,
  input  logic              indirect_shift,
  input  logic              trivial_shift,
`ifdef CORE_CTRL_SEQ_COPROC_EN
  input  logic              coproc,
  input  logic              cp_ready,
`endif
  output ctrl_cycle_t       cycle,
  output ctrl_cycle_t       next_cycle,
  output logic [BEAT_W-1:0] beat_idx,
  output logic              last_beat,
  output logic              busy
);

  localparam int unsigned TIMER_W = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [TIMER_W-1:0] TIMER_INIT =
    (MUL_LATENCY == 0) ? '0 : TIMER_W'(MUL_LATENCY - 1);

  ctrl_cycle_t       r_cycle;
  ctrl_cycle_t       w_next;
  logic [BEAT_W-1:0] r_eff;
  logic [BEAT_W-1:0] w_beat_idx;
  logic [TIMER_W-1:0] w_timer;
  logic              w_adv;
  logic              w_consume;
  logic              w_is_last;
  logic              w_xfer_done;
  logic              w_mul_done;
  logic              w_beat_clr;
  logic              w_beat_load;
  logic              w_beat_inc;
  logic              w_tmr_clr;
  logic              w_tmr_load;
  logic              w_tmr_dec;

  assign w_adv       = !bubble && !stall;
  assign w_consume   = mem_ready && !pop_valid;
  assign w_is_last   = (w_beat_idx == (r_eff - BEAT_W'(1)));
  assign w_xfer_done = (r_cycle == TRANSFER) && w_consume && w_is_last;

  // Multiply exit: external handshake when latency is zero, otherwise internal timer expiry.
  always_comb begin
    w_mul_done = 1'b0;
    if (MUL_LATENCY == 0) w_mul_done = mul_ready;
    else                  w_mul_done = (w_timer == '0);
  end

  // Next-cycle decode: bubble flushes, stall holds, otherwise per-cycle transition.
  always_comb begin
    w_next = r_cycle;
    if (bubble) begin
      w_next = ISSUE;
    end else if (!stall) begin
      case (r_cycle)
        ISSUE: begin
          if (exception)           w_next = EXCEPTION;
`ifdef CORE_CTRL_SEQ_COPROC_EN
          else if (coproc)         w_next = COPROC;
`endif
          else if (mul)            w_next = mul_add ? MUL_ACC_LD : MUL;
          else if (indirect_shift) w_next = RD_INDIRECT_SHIFT;
          else if (!trivial_shift) w_next = WITH_SHIFT;
          else                     w_next = ISSUE;
        end
        RD_INDIRECT_SHIFT: w_next = trivial_shift ? ISSUE : WITH_SHIFT;
        WITH_SHIFT,
        BASE_WRITEBACK,
        MUL_HI_WB,
        EXCEPTION:         w_next = ISSUE;
        MUL_ACC_LD:        w_next = MUL;
        MUL: begin
          if (w_mul_done) w_next = mul_long ? MUL_HI_WB : ISSUE;
        end
        TRANSFER: begin
          if (w_xfer_done) w_next = ldst_writeback ? BASE_WRITEBACK : ISSUE;
        end
`ifdef CORE_CTRL_SEQ_COPROC_EN
        COPROC:            w_next = cp_ready ? ISSUE : COPROC;
`endif
        default:           w_next = ISSUE;
      endcase
      // A memory instruction redirects any return-to-ISSUE into a fresh transfer.
      if ((w_next == ISSUE) && ldst) w_next = TRANSFER;
    end
  end

  // Control cycle register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cycle <= ISSUE;
    else     r_cycle <= w_next;
  end

  // Beat counter controls: a new transfer (including back-to-back) restarts at beat 0.
  assign w_beat_load = w_adv && (w_next == TRANSFER) && ((r_cycle != TRANSFER) || w_xfer_done);
  assign w_beat_inc  = w_adv && (r_cycle == TRANSFER) && w_consume && !w_xfer_done;
  assign w_beat_clr  = bubble || (w_adv && (r_cycle == TRANSFER) && (w_next != TRANSFER));

  // Effective beat count latched on transfer entry; zero requested beats means one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_eff <= BEAT_W'(1);
    else if (w_beat_load) r_eff <= (ldst_beats == '0) ? BEAT_W'(1) : ldst_beats;
  end

  core_control_beat_counter #(.W(BEAT_W)) u_beat_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_beat_clr),
    .i_load     (w_beat_load),
    .i_load_val ('0),
    .i_inc      (w_beat_inc),
    .i_dec      (1'b0),
    .o_count    (w_beat_idx)
  );

  // Multiply timer controls: loads on MUL entry, counts down each unstalled MUL cycle.
  assign w_tmr_load = w_adv && (w_next == MUL) && (r_cycle != MUL);
  assign w_tmr_dec  = w_adv && (r_cycle == MUL) && !w_mul_done;
  assign w_tmr_clr  = bubble || (w_adv && (r_cycle == MUL) && (w_next != MUL));

  core_control_beat_counter #(.W(TIMER_W)) u_mul_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_tmr_clr),
    .i_load     (w_tmr_load),
    .i_load_val (TIMER_INIT),
    .i_inc      (1'b0),
    .i_dec      (w_tmr_dec),
    .o_count    (w_timer)
  );

  assign cycle      = r_cycle;
  assign next_cycle = w_next;
  assign beat_idx   = w_beat_idx;
  assign last_beat  = (r_cycle == TRANSFER) && w_is_last;
  assign busy       = (r_cycle != ISSUE);

endmodule

// File: tb/tb_core_control_sequencer.sv
// Directed bench for core_control_sequencer (BEAT_W=4, MUL_LATENCY=3).
module tb_core_control_sequencer;
  import core_control_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall, bubble, exception, mul, mul_add, mul_long, mul_ready;
  logic       ldst, ldst_writeback, mem_ready, pop_valid, indirect_shift, trivial_shift;
  logic [3:0] ldst_beats;
`ifdef CORE_CTRL_SEQ_COPROC_EN
  logic       coproc, cp_ready;
`endif
  ctrl_cycle_t cycle, next_cycle;
  logic [3:0] beat_idx;
  logic       last_beat, busy;

  int checks = 0;
  int errors = 0;

  core_control_sequencer #(.BEAT_W(4), .MUL_LATENCY(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .bubble         (bubble),
    .exception      (exception),
    .mul            (mul),
    .mul_add        (mul_add),
    .mul_long       (mul_long),
    .mul_ready      (mul_ready),
    .ldst           (ldst),
    .ldst_beats     (ldst_beats),
    .ldst_writeback (ldst_writeback),
    .mem_ready      (mem_ready),
    .pop_valid      (pop_valid),
    .indirect_shift (indirect_shift),
    .trivial_shift  (trivial_shift),
`ifdef CORE_CTRL_SEQ_COPROC_EN
    .coproc         (coproc),
    .cp_ready       (cp_ready),
`endif
    .cycle          (cycle),
    .next_cycle     (next_cycle),
    .beat_idx       (beat_idx),
    .last_beat      (last_beat),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_cyc(input string tag, input ctrl_cycle_t exp);
    chk(tag, int'(cycle), int'(exp));
  endtask

  initial begin
    rst = 1'b1;
    stall = 0; bubble = 0; exception = 0; mul = 0; mul_add = 0; mul_long = 0; mul_ready = 0;
    ldst = 0; ldst_beats = 4'd0; ldst_writeback = 0; mem_ready = 0; pop_valid = 0;
    indirect_shift = 0; trivial_shift = 1;
`ifdef CORE_CTRL_SEQ_COPROC_EN
    coproc = 0; cp_ready = 0;
`endif
    #1;
    chk_cyc("rst_cycle", ISSUE);
    chk("rst_beat", int'(beat_idx), 0);
    chk("rst_last", int'(last_beat), 0);
    chk("rst_busy", int'(busy), 0);
    tick(); tick();
    rst = 1'b0;

    // Trivial ALU op: stays in ISSUE, never busy.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cyc("alu_cycle", ISSUE);
      chk("alu_busy", int'(busy), 0);
    end

    // 4-beat block transfer with base writeback.
    ldst = 1; ldst_beats = 4'd4; mem_ready = 1; ldst_writeback = 1;
    #1;
    chk("blk_next", int'(next_cycle), int'(TRANSFER));
    tick();
    ldst = 0;
    chk_cyc("blk_c0", TRANSFER);
    chk("blk_b0", int'(beat_idx), 0);
    chk("blk_l0", int'(last_beat), 0);
    chk("blk_busy", int'(busy), 1);
    tick(); chk("blk_b1", int'(beat_idx), 1); chk("blk_l1", int'(last_beat), 0);
    tick(); chk("blk_b2", int'(beat_idx), 2);
    tick(); chk("blk_b3", int'(beat_idx), 3); chk("blk_l3", int'(last_beat), 1);
    chk_cyc("blk_c3", TRANSFER);
    tick(); chk_cyc("blk_wb", BASE_WRITEBACK); chk("blk_wb_last", int'(last_beat), 0);
    tick(); chk_cyc("blk_end", ISSUE);
    ldst_writeback = 0;

    // pop_valid holds beat 1 for two cycles.
    ldst = 1; ldst_beats = 4'd4;
    tick(); ldst = 0;
    chk("pop_b0", int'(beat_idx), 0);
    tick(); chk("pop_b1", int'(beat_idx), 1);
    pop_valid = 1;
    tick(); chk("pop_h1", int'(beat_idx), 1);
    tick(); chk("pop_h2", int'(beat_idx), 1);
    pop_valid = 0;
    tick(); chk("pop_b2", int'(beat_idx), 2);
    tick(); chk("pop_b3", int'(beat_idx), 3);
    tick(); chk_cyc("pop_end", ISSUE);

    // Bubble at beat 2 aborts the transfer.
    ldst = 1;
    tick(); ldst = 0;
    tick(); tick();
    chk("bub_b2", int'(beat_idx), 2);
    bubble = 1;
    tick(); bubble = 0;
    chk_cyc("bub_cycle", ISSUE);
    chk("bub_beat", int'(beat_idx), 0);

    // Stall holds a transfer; simultaneous bubble wins.
    ldst = 1;
    tick(); ldst = 0;
    stall = 1;
    #1;
    chk("stl_next", int'(next_cycle), int'(TRANSFER));
    tick();
    chk_cyc("stl_cycle", TRANSFER);
    chk("stl_beat", int'(beat_idx), 0);
    bubble = 1;
    #1;
    chk("sb_next", int'(next_cycle), int'(ISSUE));
    tick();
    stall = 0; bubble = 0;
    chk_cyc("sb_cycle", ISSUE);
    chk("sb_beat", int'(beat_idx), 0);

    // Zero beats behaves as a single beat.
    ldst = 1; ldst_beats = 4'd0;
    tick(); ldst = 0;
    chk_cyc("z_cycle", TRANSFER);
    chk("z_last", int'(last_beat), 1);
    tick(); chk_cyc("z_end", ISSUE);

    // Accumulating long multiply, fixed latency 3.
    mul = 1; mul_add = 1; mul_long = 1;
    tick(); mul = 0; mul_add = 0;
    chk_cyc("ml_acc", MUL_ACC_LD);
    tick(); chk_cyc("ml_m1", MUL);
    tick(); chk_cyc("ml_m2", MUL);
    tick(); chk_cyc("ml_m3", MUL);
    tick(); chk_cyc("ml_hi", MUL_HI_WB);
    tick(); chk_cyc("ml_end", ISSUE);
    mul_long = 0;

    // Stall mid-MUL stretches it by the stall length.
    mul = 1;
    tick(); mul = 0;
    chk_cyc("ms_m1", MUL);
    tick(); chk_cyc("ms_m2", MUL);
    stall = 1;
    tick(); chk_cyc("ms_s1", MUL);
    tick(); chk_cyc("ms_s2", MUL);
    stall = 0;
    tick(); chk_cyc("ms_m3", MUL);
    tick(); chk_cyc("ms_end", ISSUE);

    // Exception beats multiply at ISSUE.
    exception = 1; mul = 1;
    tick(); exception = 0; mul = 0;
    chk_cyc("exc_cycle", EXCEPTION);
    tick(); chk_cyc("exc_end", ISSUE);

    // Register-specified shift.
    indirect_shift = 1; trivial_shift = 0;
    tick(); indirect_shift = 0;
    chk_cyc("sh_rd", RD_INDIRECT_SHIFT);
    tick(); trivial_shift = 1;
    chk_cyc("sh_with", WITH_SHIFT);
    tick(); chk_cyc("sh_end", ISSUE);

    // Asynchronous reset mid-transfer.
    ldst = 1; ldst_beats = 4'd4;
    tick(); ldst = 0;
    tick();
    chk("ar_b1", int'(beat_idx), 1);
    #2 rst = 1;
    #1;
    chk_cyc("ar_cycle", ISSUE);
    chk("ar_beat", int'(beat_idx), 0);
    chk("ar_busy", int'(busy), 0);
    #1 rst = 0;
    tick(); chk_cyc("ar_after", ISSUE);

`ifdef CORE_CTRL_SEQ_COPROC_EN
    // Coprocessor op held until cp_ready after five cycles.
    coproc = 1;
    tick(); coproc = 0;
    for (int i = 0; i < 5; i++) begin
      chk_cyc("cp_hold", COPROC);
      if (i == 4) cp_ready = 1;
      tick();
    end
    cp_ready = 0;
    chk_cyc("cp_end", ISSUE);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
